// File: rtl/bit_serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction sequencer.
// Optional signed-overflow output is enabled with BIT_SERIAL_SUB_OVF_EN.
package bit_serial_sub_ctrl_pkg;

  localparam int unsigned BSS_WIDTH_DEF = 8;

  localparam logic [1:0] BSS_IDLE  = 2'd0;
  localparam logic [1:0] BSS_SHIFT = 2'd1;
  localparam logic [1:0] BSS_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = BSS_IDLE,
    ST_SHIFT = BSS_SHIFT,
    ST_DONE  = BSS_DONE
  } bss_state_e;

endpackage

// File: rtl/bit_serial_sub_ctrl_full_subtractor_bit.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_sub_ctrl.sv
// LSB-first serial subtractor sequencer driving one full_subtractor_bit cell.
// Define BIT_SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_sub_ctrl
  import bit_serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = BSS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef BIT_SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  bss_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bor_q, bor_d;
  logic             cell_d, cell_bout;
`ifdef BIT_SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_subtractor_bit u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bor_d   = bor_q;
`ifdef BIT_SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d = {cell_d, r_sh_q[WIDTH-1:1]};
        bin_d  = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Final bit: the operand LSBs now hold the original MSBs
          diff_d  = {cell_d, r_sh_q[WIDTH-1:1]};
          bor_d   = cell_bout;
`ifdef BIT_SERIAL_SUB_OVF_EN
          ovf_d   = (a_sh_q[0] != b_sh_q[0]) && (cell_d != a_sh_q[0]);
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bor_q   <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bor_q   <= bor_d;
`ifdef BIT_SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bor_q;
`ifdef BIT_SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Directed self-checking bench for bit_serial_sub_ctrl (WIDTH=8).
// Checks ovf too when BIT_SERIAL_SUB_OVF_EN is defined.
module tb_bit_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef BIT_SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef BIT_SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a bound; returns the number of edges waited (99 on expiry)
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) begin
      chk({tag, "_done_timeout"}, 32'(done), 32'd1);
      n = 99;
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp_ovf);
`ifdef BIT_SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x in %s", tag);
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] exp_d, input logic exp_b, input logic exp_ovf);
    int n;
    a = ai;
    b = bi;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~ai;
    b = ~bi;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
    check_ovf(tag, exp_ovf);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_diff_hold"}, 32'(diff), 32'(exp_d));
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    check_ovf("rst", 1'b0);
    step();
    rst_n = 1'b1;
    step();

    run_op("basic",   8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("borrow",  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("sovf",    8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("zero",    8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("neg1",    8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op("povf",    8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start pulsed while busy must be ignored
    a = 8'hFF; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'h10; b = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", n);
    chk("ign_latency", 32'(3 + n), 32'd8);
    chk("ign_diff", 32'(diff), 32'hFE);
    chk("ign_borrow", 32'(borrow_out), 32'd0);
    check_ovf("ign", 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    chk("ign_no_second_op", 32'(seen), 32'd0);
    chk("ign_diff_hold", 32'(diff), 32'hFE);

    // Back-to-back: start held high across the DONE cycle
    a = 8'h05; b = 8'h03; start = 1'b1;
    step();
    a = 8'h0A; b = 8'h0B;
    wait_done("b2b1", n);
    chk("b2b1_latency", 32'(n), 32'd8);
    chk("b2b1_diff", 32'(diff), 32'h02);
    chk("b2b1_borrow", 32'(borrow_out), 32'd0);
    step();
    start = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    chk("b2b_no_idle_done", 32'(done), 32'd0);
    chk("b2b_diff_stable", 32'(diff), 32'h02);
    wait_done("b2b2", n);
    chk("b2b2_latency", 32'(n), 32'd8);
    chk("b2b2_diff", 32'(diff), 32'hFF);
    chk("b2b2_borrow", 32'(borrow_out), 32'd1);
    check_ovf("b2b2", 1'b0);
    step();
    chk("b2b2_done_pulse", 32'(done), 32'd0);

    // Reset 4 cycles into an operation
    a = 8'h55; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
    check_ovf("mid_rst", 1'b0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    run_op("after_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
